dds_rom_reader: RTL and testbench
=================================

Name: dds_rom_reader

Overview:
- Read side of the sine lookup ROM (12-bit address, 8-bit data) in the DAC datapath.
- A phase accumulator generates ROM addresses at a programmable rate and tracks ROM read latency.
- Returned sine samples are buffered and presented to the downstream DAC driver over a valid/ready stream.
- Backpressure never drops or duplicates a sample.

Parameters:
- PHASE_W, 32, phase accumulator width.
- ADDR_W, 12, ROM address width; address = phase[PHASE_W-1 -: ADDR_W].
- DATA_W, 8, ROM/sample data width.
- ROM_LAT, 1, cycles from rom_addr visible to matching rom_data visible (1..3).
- FIFO_DEPTH, 4, output buffer entries (power of 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous reset, active-low; sampled on rising edge of clk only.
- enable  in  1  level; 1 = generate samples.
- freq_word  in  PHASE_W  phase increment.
- freq_load  in  1  1-cycle strobe; latch freq_word into active increment.
- rate_div  in  16  one address issue per rate_div+1 cycles.
- rom_en  out  1  high in cycles where rom_addr carries a new request.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  DATA_W  ROM read data.
- sample_data  out  DATA_W  FIFO head.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  consumer accepts when valid&&ready.
- running  out  1  state != IDLE.

Behaviour:
- Reset (rst_n=0 at edge):
  - State IDLE; phase=0; active increment=0; rate counter=0.
  - In-flight shift register cleared; FIFO emptied.
  - Outputs: rom_en=0, rom_addr=0, sample_data=0, sample_valid=0, running=0.
  - Reset mid-operation discards all in-flight and buffered data; no sample appears afterwards.
- States:
  - IDLE: enable=1 -> RUN; phase cleared to 0 and rate counter cleared on the transition.
  - RUN: enable=0 -> DRAIN.
  - DRAIN: no new issues; when in-flight=0 and FIFO empty -> IDLE. enable=1 in DRAIN -> RUN, with phase continuing (not cleared).
- Rate tick:
  - Counter runs in RUN only.
  - tick when counter==rate_div, then counter reloads 0; otherwise counter increments.
  - rate_div=0 gives a tick every cycle.
  - rate_div changes take effect at the next compare.
- Issue condition: state RUN && tick && (fifo_count + inflight_count) < FIFO_DEPTH (credit check).
  - If a tick occurs without credit, the issue is held pending and fires on the first cycle credit is available; the tick is not lost.
  - Pending issues do not accumulate beyond 1.
- On issue, at the same edge:
  - rom_addr <= phase[PHASE_W-1 -: ADDR_W]; rom_en <= 1.
  - phase <= phase + inc, wrapping mod 2^PHASE_W.
  - Set bit 0 of the in-flight shift register.
- Otherwise rom_en <= 0 and rom_addr holds its value.
- Timing:
  - rom_data is captured into the FIFO at the end of cycle c+ROM_LAT, where c is the cycle rom_en=1.
  - With an empty FIFO, sample_valid rises ROM_LAT+1 cycles after rom_en rises.
- freq_load:
  - inc <= freq_word at the edge; the first issue using the new inc is the next issue after that edge.
  - If freq_load and an issue occur in the same cycle, that issue uses the old inc.
- FIFO:
  - Simultaneous push and pop allowed at any occupancy, including full (credit guarantees push never overflows).
  - Pop on an empty FIFO is impossible because sample_valid=0.
- sample_data and sample_valid are stable while valid=1 and ready=0.

Decomposition:
- Shared package dds_pkg:
  - Default widths: PHASE_W, ADDR_W, DATA_W.
  - State enum IDLE/RUN/DRAIN.
  - Address-extraction function.
- Natural sub-module: sample_fifo, a synchronous FIFO with parameters DATA_W and FIFO_DEPTH.
  - Inputs: push, pop, din.
  - Outputs: dout, empty, full, count.
  - Same clk/rst_n.
- Remaining logic (phase accumulator, rate counter, in-flight tracking, FSM) lives in dds_rom_reader.

Test Plan:
- Reset: hold rst_n=0 3 cycles with enable=1 -> all outputs 0, running=0; release -> RUN next edge, first rom_en=1 with rom_addr=0.
- Sweep: freq_word=0x0010_0000, rate_div=0, sample_ready=1, ROM model = sine table -> rom_addr 0,1,2,…,4095,0; sample stream equals table[n] in order; sample_valid first high 2 cycles after first rom_en (ROM_LAT=1).
- Wrap/large step: freq_word=0x8000_0000 -> rom_addr 0,2048,0,2048; freq_load with 0x0020_0000 mid-run -> next-issue step becomes 2.
- Backpressure: sample_ready=0 from start, rate_div=0 -> exactly 4 rom_en pulses, then none; FIFO holds table[0..3]; ready=1 -> samples drain in order, issues resume with the next address (4), no gaps or duplicates.
- Rate: rate_div=3 -> rom_en exactly every 4th cycle; change to 0 mid-run -> every cycle from the next compare.
- Enable drop: enable=0 with 2 in flight and 1 buffered -> no further rom_en; 3 samples delivered; running falls after the last pop; reset asserted during DRAIN -> sample_valid=0 next cycle and nothing delivered after.

Source files
------------

// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the sine-ROM read path of the DAC datapath:
//   - default widths of the phase accumulator, ROM address and sample data
//   - controller state encoding (IDLE / RUN / DRAIN)
//   - phase_to_addr(): takes the top ADDR_W bits of a PHASE_W-bit phase
// ---------------------------------------------------------------------------
package dds_pkg;

  localparam int PHASE_W_DEF = 32;
  localparam int ADDR_W_DEF  = 12;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dds_state_e;

  // The phase is passed zero-extended to 64 bits so one function serves any
  // PHASE_W/ADDR_W pair; the caller truncates the result to ADDR_W.
  function automatic logic [63:0] phase_to_addr(input logic [63:0] phase,
                                                input int         phase_w,
                                                input int         addr_w);
    return phase >> (phase_w - addr_w);
  endfunction

endpackage

// File: rtl/dds_rom_reader_if.sv
// ---------------------------------------------------------------------------
// dds_rom_reader_if
// Groups the two buses of the ROM reader:
//   ROM request  : rom_en, rom_addr (reader -> ROM), rom_data (ROM -> reader)
//   sample stream: sample_data, sample_valid (reader -> DAC driver),
//                  sample_ready (DAC driver -> reader)
// master = the reader, slave = the ROM / downstream consumer side.
// ---------------------------------------------------------------------------
interface dds_rom_reader_if #(
  parameter int ADDR_W = dds_pkg::ADDR_W_DEF,
  parameter int DATA_W = dds_pkg::DATA_W_DEF
) ();

  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;

  modport master (
    output rom_en, rom_addr, sample_data, sample_valid,
    input  rom_data, sample_ready
  );

  modport slave (
    input  rom_en, rom_addr, sample_data, sample_valid,
    output rom_data, sample_ready
  );

endinterface

// File: rtl/dds_rom_reader_sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo
// Synchronous FIFO holding returned sine samples until the DAC driver takes
// them. Push and pop may happen in the same cycle at any occupancy.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   push, din    write strobe and data
//   pop          read strobe (head is consumed)
//   dout         head entry (0 while empty)
//   empty, full  occupancy flags
//   count        number of stored entries
// ---------------------------------------------------------------------------
module sample_fifo
  import dds_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic [DATA_W-1:0]           din,
  output logic [DATA_W-1:0]           dout,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic              w_do_pop;
  logic              w_do_push;

  // Guard strobes so an illegal pop/push can never corrupt the pointers;
  // a push into a full FIFO is legal when a pop frees the head this cycle.
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  assign empty = (r_count == '0);
  assign full  = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
  assign count = r_count;
  assign dout  = empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents are don't-care while not covered by r_count.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/dds_rom_reader.sv
// ---------------------------------------------------------------------------
// dds_rom_reader
// Read side of the sine lookup ROM. A phase accumulator issues ROM addresses
// at a programmable rate, an in-flight shift register tracks the ROM read
// latency, and returned samples are buffered in sample_fifo and offered to
// the DAC driver over a valid/ready stream. Issues are credit-limited so the
// FIFO can never overflow and no sample is ever dropped or duplicated.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   enable       level, 1 = generate samples
//   freq_word    phase increment, latched by the freq_load strobe
//   rate_div     one address issue per rate_div+1 cycles
//   running      controller not idle
//   bus          ROM request bus and sample stream (master side)
// ---------------------------------------------------------------------------
module dds_rom_reader
  import dds_pkg::*;
#(
  parameter int PHASE_W    = PHASE_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ROM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [PHASE_W-1:0]  freq_word,
  input  logic                freq_load,
  input  logic [15:0]         rate_div,
  output logic                running,
  dds_rom_reader_if.master    bus
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam int         CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int         SUM_W   = CNT_W + 3;

  logic [1:0]         r_state;
  logic [PHASE_W-1:0] r_phase;
  logic [PHASE_W-1:0] r_inc;
  logic [15:0]        r_rate_cnt;
  logic               r_pending;
  logic [ROM_LAT:0]   r_inflight;   // bit k set: request issued k cycles ago
  logic               r_rom_en;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic               r_running;

  logic [1:0]         w_state_nxt;
  logic               w_tick;
  logic               w_credit;
  logic               w_issue;
  logic               w_start;
  logic               w_pop;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic [CNT_W-1:0]   w_fifo_count;
  logic [SUM_W-1:0]   w_inflight_cnt;
  logic [SUM_W-1:0]   w_occupancy;
  logic [ADDR_W-1:0]  w_addr;

  assign w_addr = ADDR_W'(phase_to_addr(64'(r_phase), PHASE_W, ADDR_W));

  // Count requests still travelling through the ROM pipeline.
  always_comb begin
    w_inflight_cnt = '0;
    for (int i = 0; i <= ROM_LAT; i++) begin
      w_inflight_cnt = w_inflight_cnt + SUM_W'(r_inflight[i]);
    end
  end

  // The compare is >= so that lowering rate_div below the running count
  // still ticks on the next cycle instead of waiting for the counter to wrap.
  assign w_tick      = (r_state == S_RUN) && (r_rate_cnt >= rate_div);
  assign w_occupancy = SUM_W'(w_fifo_count) + w_inflight_cnt;
  assign w_credit    = (w_occupancy < SUM_W'(FIFO_DEPTH)) && !w_fifo_full;
  assign w_issue     = (r_state == S_RUN) && (w_tick || r_pending) && w_credit;
  assign w_start     = (r_state == S_IDLE) && (w_state_nxt == S_RUN);
  assign w_pop       = !w_fifo_empty && bus.sample_ready;

  // Next-state decode of the IDLE/RUN/DRAIN controller.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (enable) w_state_nxt = S_RUN;
        else        w_state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (!enable) w_state_nxt = S_DRAIN;
        else         w_state_nxt = S_RUN;
      end
      S_DRAIN: begin
        if (enable)                                    w_state_nxt = S_RUN;
        else if ((r_inflight == '0) && w_fifo_empty)   w_state_nxt = S_IDLE;
        else                                           w_state_nxt = S_DRAIN;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Controller state, phase accumulator, rate counter and request tracking.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_running  <= 1'b0;
      r_phase    <= '0;
      r_inc      <= '0;
      r_rate_cnt <= 16'd0;
      r_pending  <= 1'b0;
      r_inflight <= '0;
      r_rom_en   <= 1'b0;
      r_rom_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_running  <= (w_state_nxt != S_IDLE);
      r_inflight <= {r_inflight[ROM_LAT-1:0], w_issue};
      r_rom_en   <= w_issue;
      if (w_issue) r_rom_addr <= w_addr;
      // The issue uses the old increment even when freq_load arrives with it.
      if (freq_load) r_inc <= freq_word;
      if (w_start)      r_phase <= '0;
      else if (w_issue) r_phase <= r_phase + r_inc;
      if (w_start)                r_rate_cnt <= 16'd0;
      else if (r_state == S_RUN)  r_rate_cnt <= w_tick ? 16'd0 : r_rate_cnt + 16'd1;
      // A tick without credit waits here; at most one issue is ever owed.
      if (r_state == S_RUN) r_pending <= (w_tick || r_pending) && !w_credit;
      else                  r_pending <= 1'b0;
    end
  end

  sample_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight[ROM_LAT]),
    .pop   (w_pop),
    .din   (bus.rom_data),
    .dout  (bus.sample_data),
    .empty (w_fifo_empty),
    .full  (w_fifo_full),
    .count (w_fifo_count)
  );

  assign bus.rom_en       = r_rom_en;
  assign bus.rom_addr     = r_rom_addr;
  assign bus.sample_valid = !w_fifo_empty;
  assign running          = r_running;

endmodule

// File: tb/tb_dds_rom_reader.sv
// ---------------------------------------------------------------------------
// tb_dds_rom_reader
// Scoreboard bench for dds_rom_reader: a reference phase model predicts every
// ROM address; the sine value of that address is queued at issue time and
// compared against each accepted sample.
// ---------------------------------------------------------------------------
module tb_dds_rom_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        freq_load = 1'b0;
  logic [31:0] freq_word = 32'd0;
  logic [15:0] rate_div = 16'd0;
  logic        running;

  dds_rom_reader_if bus ();

  dds_rom_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .freq_word (freq_word),
    .freq_load (freq_load),
    .rate_div  (rate_div),
    .running   (running),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  sine_tab [4096];
  logic [7:0]  sb [$];
  logic [11:0] addr_log [$];
  int          en_cyc [$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_rom_en = 0;
  int          n_pop = 0;
  int          last_pop_cyc = 0;
  logic [31:0] m_phase = 32'd0;
  logic [31:0] m_inc = 32'd0;
  logic        cap_rst = 1'b0, cap_load = 1'b0, cap_pop = 1'b0, cap_stall = 1'b0;
  logic [31:0] cap_val = 32'd0;
  logic [7:0]  cap_data = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    freq_load = 1'b0;
    step(3);
    rst_n = 1'b1;
  endtask

  task automatic load_freq(input logic [31:0] v);
    freq_word = v;
    freq_load = 1'b1;
    step(1);
    freq_load = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 60 && running !== 1'b0; k++) step(1);
    chk(tag, 32'(running), 32'd0);
  endtask

  // ROM model with one cycle of read latency.
  always @(posedge clk) bus.rom_data <= sine_tab[bus.rom_addr];

  // Capture what the DUT samples at each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      cap_rst   = !rst_n;
      cap_load  = freq_load && rst_n;
      cap_val   = freq_word;
      cap_pop   = (bus.sample_valid === 1'b1) && (bus.sample_ready === 1'b1) && rst_n;
      cap_stall = (bus.sample_valid === 1'b1) && (bus.sample_ready !== 1'b1) && rst_n;
      cap_data  = bus.sample_data;
    end
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  initial begin
    logic [11:0] exp_addr;
    forever begin
      @(negedge clk);
      if (cap_rst) begin
        sb.delete();
        addr_log.delete();
        en_cyc.delete();
        m_phase = 32'd0;
        m_inc = 32'd0;
        n_rom_en = 0;
        n_pop = 0;
      end else begin
        if (bus.rom_en === 1'b1) begin
          exp_addr = m_phase[31:20];
          chk("rom_addr", 32'(bus.rom_addr), 32'(exp_addr));
          sb.push_back(sine_tab[exp_addr]);
          addr_log.push_back(bus.rom_addr);
          en_cyc.push_back(cyc);
          n_rom_en++;
          m_phase = m_phase + m_inc;
        end
        if (cap_load) m_inc = cap_val;
        if (cap_stall) begin
          chk("stall_valid", 32'(bus.sample_valid), 32'd1);
          chk("stall_data", 32'(bus.sample_data), 32'(cap_data));
        end
        if (cap_pop) begin
          chk("sample_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) chk("sample_data", 32'(cap_data), 32'(sb.pop_front()));
          n_pop++;
          last_pop_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] wrap_exp [4];
    int          n;
    int          fall_cyc;
    wrap_exp[0] = 12'd0; wrap_exp[1] = 12'd2048; wrap_exp[2] = 12'd0; wrap_exp[3] = 12'd2048;
    for (int i = 0; i < 4096; i++)
      sine_tab[i] = 8'($rtoi(127.5 + 127.0 * $sin(6.283185307179586 * real'(i) / 4096.0)));
    bus.sample_ready = 1'b1;

    // Reset held with enable=1, then release.
    enable = 1'b1;
    step(3);
    chk("rst_rom_en", 32'(bus.rom_en), 32'd0);
    chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    chk("rst_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_data", 32'(bus.sample_data), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    rst_n = 1'b1;
    step(1);
    chk("rel_running", 32'(running), 32'd1);
    chk("rel_no_en_yet", 32'(bus.rom_en), 32'd0);
    step(1);
    chk("rel_first_en", 32'(bus.rom_en), 32'd1);
    chk("rel_first_addr", 32'(bus.rom_addr), 32'd0);

    // Full address sweep with unit step.
    do_reset();
    rate_div = 16'd0;
    bus.sample_ready = 1'b1;
    load_freq(32'h0010_0000);
    enable = 1'b1;
    for (int k = 0; k < 20 && bus.sample_valid !== 1'b1; k++) step(1);
    chk("sweep_valid_seen", 32'(bus.sample_valid), 32'd1);
    chk("sweep_en_seen", 32'(en_cyc.size() != 0), 32'd1);
    if (en_cyc.size() != 0) chk("sweep_valid_latency", 32'(cyc - en_cyc[0]), 32'd2);
    for (int k = 0; k < 6000 && n_rom_en < 4097; k++) step(1);
    chk("sweep_issue_count", 32'(n_rom_en >= 4097), 32'd1);
    enable = 1'b0;
    wait_idle("sweep_idle");
    chk("sweep_sb_empty", 32'(sb.size()), 32'd0);
    if (addr_log.size() > 4096) begin
      chk("sweep_addr_4095", 32'(addr_log[4095]), 32'd4095);
      chk("sweep_addr_wrap", 32'(addr_log[4096]), 32'd0);
    end

    // Half-circle step, then a mid-run frequency change.
    do_reset();
    load_freq(32'h8000_0000);
    enable = 1'b1;
    for (int k = 0; k < 30 && n_rom_en < 4; k++) step(1);
    load_freq(32'h0020_0000);
    for (int k = 0; k < 30 && n_rom_en < 14; k++) step(1);
    enable = 1'b0;
    wait_idle("wrap_idle");
    n = addr_log.size();
    chk("wrap_issue_count", 32'(n >= 14), 32'd1);
    if (n >= 14) begin
      for (int i = 0; i < 4; i++) chk("wrap_addr", 32'(addr_log[i]), 32'(wrap_exp[i]));
      chk("wrap_new_step", 32'(12'(addr_log[n-1] - addr_log[n-2])), 32'd2);
    end
    chk("wrap_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure from the start: credit stops issues at four.
    do_reset();
    bus.sample_ready = 1'b0;
    load_freq(32'h0010_0000);
    enable = 1'b1;
    step(20);
    chk("bp_issue_count", 32'(n_rom_en), 32'd4);
    chk("bp_valid", 32'(bus.sample_valid), 32'd1);
    chk("bp_head", 32'(bus.sample_data), 32'(sine_tab[0]));
    bus.sample_ready = 1'b1;
    for (int k = 0; k < 60 && n_rom_en < 12; k++) step(1);
    enable = 1'b0;
    wait_idle("bp_idle");
    chk("bp_resume_addr", 32'(addr_log.size() > 4 ? addr_log[4] : 12'hFFF), 32'd4);
    chk("bp_pop_eq_issue", 32'(n_pop), 32'(n_rom_en));
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Rate divider at 4 cycles, then back to every cycle.
    do_reset();
    load_freq(32'h0010_0000);
    rate_div = 16'd3;
    enable = 1'b1;
    for (int k = 0; k < 40 && n_rom_en < 5; k++) step(1);
    chk("rate_issue_count", 32'(n_rom_en >= 5), 32'd1);
    if (en_cyc.size() >= 5)
      for (int i = 1; i < 5; i++) chk("rate_div3_gap", 32'(en_cyc[i] - en_cyc[i-1]), 32'd4);
    rate_div = 16'd0;
    step(10);
    n = en_cyc.size();
    if (n >= 10)
      for (int i = n - 4; i < n; i++) chk("rate_div0_gap", 32'(en_cyc[i] - en_cyc[i-1]), 32'd1);
    enable = 1'b0;
    wait_idle("rate_idle");

    // Enable drop with two requests in flight and one sample buffered.
    do_reset();
    bus.sample_ready = 1'b0;
    load_freq(32'h0010_0000);
    enable = 1'b1;
    for (int k = 0; k < 20 && n_rom_en < 2; k++) step(1);
    enable = 1'b0;
    step(8);
    chk("drop_issue_count", 32'(n_rom_en), 32'd3);
    chk("drop_running", 32'(running), 32'd1);
    chk("drop_valid", 32'(bus.sample_valid), 32'd1);
    bus.sample_ready = 1'b1;
    for (int k = 0; k < 20 && running !== 1'b0; k++) step(1);
    fall_cyc = cyc;
    chk("drop_idle", 32'(running), 32'd0);
    chk("drop_delivered", 32'(n_pop), 32'd3);
    chk("drop_fall_after_pop", 32'(fall_cyc - last_pop_cyc), 32'd1);

    // Reset during DRAIN discards everything.
    do_reset();
    bus.sample_ready = 1'b0;
    load_freq(32'h0010_0000);
    enable = 1'b1;
    for (int k = 0; k < 20 && n_rom_en < 2; k++) step(1);
    enable = 1'b0;
    step(4);
    chk("drst_in_drain", 32'(running), 32'd1);
    rst_n = 1'b0;
    step(1);
    chk("drst_valid", 32'(bus.sample_valid), 32'd0);
    chk("drst_running", 32'(running), 32'd0);
    rst_n = 1'b1;
    bus.sample_ready = 1'b1;
    step(10);
    chk("drst_no_pop", 32'(n_pop), 32'd0);
    chk("drst_no_issue", 32'(n_rom_en), 32'd0);
    chk("drst_valid_after", 32'(bus.sample_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
